// File: rtl/axil_periph_regs_pkg.sv
// axil_periph_pkg: shared constants and helpers for the AXI4-lite peripheral
// register block (register byte offsets, response codes, CTRL bit indices,
// seven-segment pattern lookup and byte-strobe merge).
package axil_periph_pkg;

  localparam logic [4:0] REG_CTRL        = 5'h00;
  localparam logic [4:0] REG_LED         = 5'h04;
  localparam logic [4:0] REG_SEG         = 5'h08;
  localparam logic [4:0] REG_IRQ_STATUS  = 5'h0C;
  localparam logic [4:0] REG_IRQ_ENABLE  = 5'h10;
  localparam logic [4:0] REG_TIMER_LOAD  = 5'h14;
  localparam logic [4:0] REG_TIMER_COUNT = 5'h18;
  // First byte offset that decodes to SLVERR.
  localparam int unsigned REG_LIMIT = 32'h1C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned CTRL_TIMER_EN  = 0;
  localparam int unsigned CTRL_LED_BLANK = 1;
  localparam int unsigned CTRL_SEG_BLANK = 2;

  // Hex digit to {dp,g,f,e,d,c,b,a}, active-high, dp always off.
  function automatic logic [7:0] seg7_pattern(input logic [3:0] nib);
    case (nib)
      4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
      4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
      4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
      4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
    endcase
  endfunction

  // Replace each byte of old_word whose strobe is set with the matching byte of data.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int unsigned k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = data[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_periph_regs_if.sv
// axil_periph_regs_if: AXI4-lite bus bundle for axil_periph_regs.
// Channels: AW (addr/valid/ready), W (data/strb/valid/ready), B (resp/valid/ready),
// AR (addr/valid/ready), R (data/resp/valid/ready). Modports: master, slave.
interface axil_periph_regs_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] S_AWADDR;
  logic                  S_AWVALID;
  logic                  S_AWREADY;
  logic [31:0]           S_WDATA;
  logic [3:0]            S_WSTRB;
  logic                  S_WVALID;
  logic                  S_WREADY;
  logic [1:0]            S_BRESP;
  logic                  S_BVALID;
  logic                  S_BREADY;
  logic [ADDR_WIDTH-1:0] S_ARADDR;
  logic                  S_ARVALID;
  logic                  S_ARREADY;
  logic [31:0]           S_RDATA;
  logic [1:0]            S_RRESP;
  logic                  S_RVALID;
  logic                  S_RREADY;

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );
endinterface

// File: rtl/axil_periph_regs_sevenseg_dec.sv
// axil_sevenseg_dec: combinational hex nibble to seven-segment pattern.
// Ports: nibble (in, 4) hex digit; seg (out, 8) {dp,g,f,e,d,c,b,a}, active-high.
module axil_sevenseg_dec
  import axil_periph_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);
  assign seg = seg7_pattern(nibble);
endmodule

// File: rtl/axil_periph_regs.sv
// axil_periph_regs: AXI4-lite leaf slave with LED bank, seven-segment display
// and (optional) countdown timer with level interrupt.
// Ports: ACLK clock; ARESET async active-high reset; s_axil AXI4-lite slave
// bundle; LED_OUT registered LED drive; SEVENSEG_OUT decoded digits
// (digit i at [8i+7:8i]); IRQ_OUT registered level interrupt.
// Build option: define AXIL_PERIPH_TIMER_EN to include the timer, TIMER_LOAD/
// TIMER_COUNT, IRQ_STATUS/IRQ_ENABLE and IRQ_OUT; otherwise those read 0/OKAY.
module axil_periph_regs
  import axil_periph_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LED_W      = 8,
  parameter int NUM_DIGITS = 4,
  parameter int TIMER_W    = 24
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  axil_periph_regs_if.slave       s_axil,
  output logic [LED_W-1:0]        LED_OUT,
  output logic [8*NUM_DIGITS-1:0] SEVENSEG_OUT,
  output logic                    IRQ_OUT
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axil_periph_regs: DATA_WIDTH must be 32");
  end

  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [LED_W-1:0] led_q, led_d, led_out_q, led_out_d;
  logic [4*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [8*NUM_DIGITS-1:0] seg_out_q, seg_out_d, seg_dec;
  logic seg_refresh_q, seg_refresh_d;

  logic aw_hs, w_hs, ar_hs, do_write, wr_reg, wr_err, rd_err;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0] wr_data, wr_word, rd_word;
  logic [3:0]  wr_strb;
  logic [4:0]  wr_off, rd_off;

`ifdef AXIL_PERIPH_TIMER_EN
  logic irq_status_q, irq_status_d, irq_en_q, irq_en_d, irq_out_q, irq_out_d;
  logic [TIMER_W-1:0] load_q, load_d, count_q, count_d;
  logic w1c, irq_set, timer_start;
`else
  localparam int unused_timer_w = TIMER_W;
`endif

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    axil_sevenseg_dec u_dec (.nibble(seg_q[4*i +: 4]), .seg(seg_dec[8*i +: 8]));
  end

  always_comb begin
    aw_done_d = aw_done_q;  w_done_d = w_done_q;
    awaddr_d  = awaddr_q;   wdata_d  = wdata_q;   wstrb_d = wstrb_q;
    bvalid_d  = bvalid_q;   bresp_d  = bresp_q;
    rvalid_d  = rvalid_q;   rresp_d  = rresp_q;   rdata_d = rdata_q;
    ctrl_d    = ctrl_q;     led_d    = led_q;     seg_d   = seg_q;
    wr_word   = '0;         rd_word  = '0;
`ifdef AXIL_PERIPH_TIMER_EN
    irq_status_d = irq_status_q;  irq_en_d = irq_en_q;
    load_d = load_q;  count_d = count_q;
    w1c = 1'b0;  irq_set = 1'b0;  timer_start = 1'b0;
`endif

    // Each channel latches independently; the commit uses the live bus value
    // for whichever half is handshaking this cycle.
    aw_hs    = s_axil.S_AWVALID & ~aw_done_q;
    w_hs     = s_axil.S_WVALID  & ~w_done_q;
    ar_hs    = s_axil.S_ARVALID & ~rvalid_q;
    wr_addr  = aw_done_q ? awaddr_q : s_axil.S_AWADDR;
    wr_data  = w_done_q  ? wdata_q  : s_axil.S_WDATA;
    wr_strb  = w_done_q  ? wstrb_q  : s_axil.S_WSTRB;
    wr_err   = wr_addr >= ADDR_WIDTH'(REG_LIMIT);
    wr_off   = {wr_addr[4:2], 2'b00};
    do_write = ~bvalid_q & (aw_done_q | aw_hs) & (w_done_q | w_hs);
    wr_reg   = do_write & ~wr_err;

    if (aw_hs) begin aw_done_d = 1'b1; awaddr_d = s_axil.S_AWADDR; end
    if (w_hs)  begin w_done_d = 1'b1; wdata_d = s_axil.S_WDATA; wstrb_d = s_axil.S_WSTRB; end

    if (do_write) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
    end else if (bvalid_q & s_axil.S_BREADY) begin
      bvalid_d = 1'b0;  aw_done_d = 1'b0;  w_done_d = 1'b0;
    end

    if (wr_reg) begin
      case (wr_off)
        REG_CTRL: begin
          wr_word = apply_wstrb(32'(ctrl_q), wr_data, wr_strb);
          ctrl_d  = wr_word[2:0];
        end
        REG_LED: begin
          wr_word = apply_wstrb(32'(led_q), wr_data, wr_strb);
          led_d   = wr_word[LED_W-1:0];
        end
        REG_SEG: begin
          wr_word = apply_wstrb(32'(seg_q), wr_data, wr_strb);
          seg_d   = wr_word[4*NUM_DIGITS-1:0];
        end
`ifdef AXIL_PERIPH_TIMER_EN
        REG_IRQ_STATUS: w1c = wr_strb[0] & wr_data[0];
        REG_IRQ_ENABLE: if (wr_strb[0]) irq_en_d = wr_data[0];
        REG_TIMER_LOAD: begin
          wr_word = apply_wstrb(32'(load_q), wr_data, wr_strb);
          load_d  = wr_word[TIMER_W-1:0];
        end
`endif
        default: ;
      endcase
    end

`ifdef AXIL_PERIPH_TIMER_EN
    timer_start = wr_reg & (wr_off == REG_CTRL) & ~ctrl_q[CTRL_TIMER_EN] & ctrl_d[CTRL_TIMER_EN];
    if (timer_start) begin
      count_d = load_q;
    end else if (ctrl_q[CTRL_TIMER_EN]) begin
      if (count_q == '0) begin
        count_d = load_q;
        irq_set = 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
    // Expiry is applied after the clear so a coincident W1C loses.
    if (w1c)     irq_status_d = 1'b0;
    if (irq_set) irq_status_d = 1'b1;
    irq_out_d = irq_status_q & irq_en_q;
`else
    ctrl_d[CTRL_TIMER_EN] = 1'b0;
`endif

    rd_err = s_axil.S_ARADDR >= ADDR_WIDTH'(REG_LIMIT);
    rd_off = {s_axil.S_ARADDR[4:2], 2'b00};
    case (rd_off)
      REG_CTRL:        rd_word = 32'(ctrl_q);
      REG_LED:         rd_word = 32'(led_q);
      REG_SEG:         rd_word = 32'(seg_q);
`ifdef AXIL_PERIPH_TIMER_EN
      REG_IRQ_STATUS:  rd_word = 32'(irq_status_q);
      REG_IRQ_ENABLE:  rd_word = 32'(irq_en_q);
      REG_TIMER_LOAD:  rd_word = 32'(load_q);
      REG_TIMER_COUNT: rd_word = 32'(count_q);
`endif
      default:         rd_word = '0;
    endcase
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
      rdata_d  = rd_err ? '0 : rd_word;
    end else if (rvalid_q & s_axil.S_RREADY) begin
      rvalid_d = 1'b0;
    end

    led_out_d = ctrl_q[CTRL_LED_BLANK] ? '0 : led_q;
    // The display stays dark out of reset and refreshes the cycle after any
    // write commit, so an unprogrammed board does not show "0000".
    seg_refresh_d = do_write;
    seg_out_d     = seg_out_q;
    if (seg_refresh_q) seg_out_d = ctrl_q[CTRL_SEG_BLANK] ? '0 : seg_dec;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_done_q <= 1'b0;  w_done_q <= 1'b0;
      awaddr_q  <= '0;    wdata_q  <= '0;   wstrb_q <= '0;
      bvalid_q  <= 1'b0;  bresp_q  <= '0;
      rvalid_q  <= 1'b0;  rresp_q  <= '0;   rdata_q <= '0;
      ctrl_q    <= '0;    led_q    <= '0;   seg_q   <= '0;
      led_out_q <= '0;    seg_out_q <= '0;  seg_refresh_q <= 1'b0;
`ifdef AXIL_PERIPH_TIMER_EN
      irq_status_q <= 1'b0;  irq_en_q <= 1'b0;  irq_out_q <= 1'b0;
      load_q <= '0;  count_q <= '0;
`endif
    end else begin
      aw_done_q <= aw_done_d;  w_done_q <= w_done_d;
      awaddr_q  <= awaddr_d;   wdata_q  <= wdata_d;   wstrb_q <= wstrb_d;
      bvalid_q  <= bvalid_d;   bresp_q  <= bresp_d;
      rvalid_q  <= rvalid_d;   rresp_q  <= rresp_d;   rdata_q <= rdata_d;
      ctrl_q    <= ctrl_d;     led_q    <= led_d;     seg_q   <= seg_d;
      led_out_q <= led_out_d;  seg_out_q <= seg_out_d; seg_refresh_q <= seg_refresh_d;
`ifdef AXIL_PERIPH_TIMER_EN
      irq_status_q <= irq_status_d;  irq_en_q <= irq_en_d;  irq_out_q <= irq_out_d;
      load_q <= load_d;  count_q <= count_d;
`endif
    end
  end

  logic unused_bits;
  assign unused_bits = ^wr_word;

  assign s_axil.S_AWREADY = ~aw_done_q;
  assign s_axil.S_WREADY  = ~w_done_q;
  assign s_axil.S_BVALID  = bvalid_q;
  assign s_axil.S_BRESP   = bresp_q;
  assign s_axil.S_ARREADY = ~rvalid_q;
  assign s_axil.S_RVALID  = rvalid_q;
  assign s_axil.S_RRESP   = rresp_q;
  assign s_axil.S_RDATA   = rdata_q;
  assign LED_OUT          = led_out_q;
  assign SEVENSEG_OUT     = seg_out_q;
`ifdef AXIL_PERIPH_TIMER_EN
  assign IRQ_OUT = irq_out_q;
`else
  assign IRQ_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_axil_periph_regs.sv
// tb_axil_periph_regs: directed self-checking bench for axil_periph_regs
// (default parameters). Timer checks build only with AXIL_PERIPH_TIMER_EN.
module tb_axil_periph_regs;

  logic        ACLK;
  logic        ARESET;
  logic [7:0]  LED_OUT;
  logic [31:0] SEVENSEG_OUT;
  logic        IRQ_OUT;
  int checks;
  int failures;

  axil_periph_regs_if #(.ADDR_WIDTH(8)) bus ();

  axil_periph_regs #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .LED_W(8), .NUM_DIGITS(4), .TIMER_W(24)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .s_axil(bus),
    .LED_OUT(LED_OUT), .SEVENSEG_OUT(SEVENSEG_OUT), .IRQ_OUT(IRQ_OUT)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic idle_bus();
    bus.S_AWADDR = '0; bus.S_AWVALID = 1'b0; bus.S_WDATA = '0; bus.S_WSTRB = '0;
    bus.S_WVALID = 1'b0; bus.S_BREADY = 1'b0; bus.S_ARADDR = '0; bus.S_ARVALID = 1'b0;
    bus.S_RREADY = 1'b0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    idle_bus();
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
  endtask

  // All transaction tasks start and end at #1 after a rising edge.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_pend, w_pend, aw_go, w_go;
    int n;
    bus.S_AWADDR = addr; bus.S_AWVALID = 1'b1;
    bus.S_WDATA = data; bus.S_WSTRB = strb; bus.S_WVALID = 1'b1;
    aw_pend = 1'b1; w_pend = 1'b1; n = 0;
    while ((aw_pend || w_pend) && n < 20) begin
      aw_go = bus.S_AWVALID && bus.S_AWREADY;
      w_go  = bus.S_WVALID && bus.S_WREADY;
      @(posedge ACLK); #1;
      if (aw_go) begin bus.S_AWVALID = 1'b0; aw_pend = 1'b0; end
      if (w_go)  begin bus.S_WVALID = 1'b0;  w_pend = 1'b0;  end
      n++;
    end
    bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0;
    n = 0;
    while (!bus.S_BVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    checks++;
    if (bus.S_BVALID !== 1'b1) begin
      failures++;
      $display("FAIL write_bvalid addr=%h got=%b want=1", addr, bus.S_BVALID);
    end
    resp = bus.S_BRESP;
    bus.S_BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    logic ar_go;
    bus.S_ARADDR = addr; bus.S_ARVALID = 1'b1;
    n = 0; ar_go = 1'b0;
    while (!ar_go && n < 20) begin
      ar_go = bus.S_ARREADY;
      @(posedge ACLK); #1;
      n++;
    end
    bus.S_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_RVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    checks++;
    if (bus.S_RVALID !== 1'b1) begin
      failures++;
      $display("FAIL read_rvalid addr=%h got=%b want=1", addr, bus.S_RVALID);
    end
    data = bus.S_RDATA; resp = bus.S_RRESP;
    bus.S_RREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_RREADY = 1'b0;
  endtask

  task automatic expect_read(input string name, input logic [7:0] addr,
                             input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    checks++;
    if ({d, r} !== {exp_data, exp_resp}) begin
      failures++;
      $display("FAIL %s addr=%h got data=%h resp=%b want data=%h resp=%b",
               name, addr, d, r, exp_data, exp_resp);
    end
  endtask

  task automatic expect_write(input string name, input logic [7:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] r;
    axi_write(addr, data, strb, r);
    checks++;
    if (r !== exp_resp) begin
      failures++;
      $display("FAIL %s addr=%h got bresp=%b want %b", name, addr, r, exp_resp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY, bus.S_BVALID, bus.S_RVALID,
         bus.S_BRESP, bus.S_RRESP, bus.S_RDATA} !== {3'b111, 2'b00, 4'b0000, 32'h0}) begin
      failures++;
      $display("FAIL reset_bus got aw/w/ar=%b%b%b b/r=%b%b bresp=%b rresp=%b rdata=%h",
               bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY, bus.S_BVALID, bus.S_RVALID,
               bus.S_BRESP, bus.S_RRESP, bus.S_RDATA);
    end
    for (int unsigned a = 0; a <= 8'h18; a += 4)
      expect_read("reset_reg", 8'(a), 32'h0, 2'b00);
    checks++;
    if ({LED_OUT, SEVENSEG_OUT, IRQ_OUT} !== 41'h0) begin
      failures++;
      $display("FAIL reset_outputs got led=%h seg=%h irq=%b want 0", LED_OUT, SEVENSEG_OUT, IRQ_OUT);
    end
  endtask

  // AW alone, W three cycles later, then a 5-cycle BREADY stall.
  task automatic test_aw_then_w();
    bus.S_AWADDR = 8'h04; bus.S_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AWVALID = 1'b0;
    checks++;
    if ({bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID} !== 3'b010) begin
      failures++;
      $display("FAIL aw_only got awready=%b wready=%b bvalid=%b want 0 1 0",
               bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID);
    end
    repeat (2) @(posedge ACLK); #1;
    checks++;
    if (bus.S_BVALID !== 1'b0) begin
      failures++; $display("FAIL aw_wait_bvalid got=%b want 0", bus.S_BVALID);
    end
    bus.S_WDATA = 32'h000000A5; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_WVALID = 1'b0;
    checks++;
    if ({bus.S_BVALID, bus.S_BRESP, LED_OUT} !== {1'b1, 2'b00, 8'h00}) begin
      failures++;
      $display("FAIL w_commit got bvalid=%b bresp=%b led=%h want 1 00 00",
               bus.S_BVALID, bus.S_BRESP, LED_OUT);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge ACLK); #1;
      checks++;
      if ({bus.S_BVALID, bus.S_BRESP, bus.S_AWREADY, bus.S_WREADY, LED_OUT} !==
          {1'b1, 2'b00, 2'b00, 8'hA5}) begin
        failures++;
        $display("FAIL bready_stall cyc=%0d got bvalid=%b bresp=%b aw/w=%b%b led=%h want 1 00 00 a5",
                 i, bus.S_BVALID, bus.S_BRESP, bus.S_AWREADY, bus.S_WREADY, LED_OUT);
      end
    end
    bus.S_BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_BREADY = 1'b0;
    checks++;
    if ({bus.S_BVALID, bus.S_AWREADY, bus.S_WREADY} !== 3'b011) begin
      failures++;
      $display("FAIL b_done got bvalid=%b aw/w=%b%b want 0 11",
               bus.S_BVALID, bus.S_AWREADY, bus.S_WREADY);
    end
  endtask

  task automatic test_strobes();
    expect_write("led_strb1_wr", 8'h04, 32'hFFFFFF5A, 4'h1, 2'b00);
    expect_read("led_strb1", 8'h04, 32'h5A, 2'b00);
    expect_write("led_strb0_wr", 8'h04, 32'h12345633, 4'h0, 2'b00);
    expect_read("led_strb0", 8'h04, 32'h5A, 2'b00);
    expect_write("led_strb2_wr", 8'h04, 32'h00001234, 4'h2, 2'b00);
    expect_read("led_strb2", 8'h04, 32'h5A, 2'b00);
    checks++;
    if (LED_OUT !== 8'h5A) begin
      failures++; $display("FAIL led_out got=%h want 5a", LED_OUT);
    end
  endtask

  task automatic test_seg();
    expect_write("seg_wr1", 8'h08, 32'h00003210, 4'h1, 2'b00);
    expect_read("seg_rd1", 8'h08, 32'h10, 2'b00);
    checks++;
    if (SEVENSEG_OUT !== 32'h3F3F063F) begin
      failures++; $display("FAIL seg_out1 got=%h want 3f3f063f", SEVENSEG_OUT);
    end
    expect_write("seg_wr2", 8'h08, 32'hFEDCBA98, 4'hF, 2'b00);
    expect_read("seg_rd2", 8'h08, 32'h0000BA98, 2'b00);
    checks++;
    if (SEVENSEG_OUT !== 32'h7C776F7F) begin
      failures++; $display("FAIL seg_out2 got=%h want 7c776f7f", SEVENSEG_OUT);
    end
  endtask

  task automatic test_ctrl_blank();
    expect_write("ctrl_blank_wr", 8'h00, 32'h00000006, 4'hF, 2'b00);
    expect_read("ctrl_blank_rd", 8'h00, 32'h6, 2'b00);
    checks++;
    if ({LED_OUT, SEVENSEG_OUT} !== 40'h0) begin
      failures++; $display("FAIL blanked got led=%h seg=%h want 0", LED_OUT, SEVENSEG_OUT);
    end
    expect_write("ctrl_unblank_wr", 8'h00, 32'h00000000, 4'hF, 2'b00);
    checks++;
    if ({LED_OUT, SEVENSEG_OUT} !== {8'h5A, 32'h7C776F7F}) begin
      failures++; $display("FAIL unblanked got led=%h seg=%h want 5a 7c776f7f", LED_OUT, SEVENSEG_OUT);
    end
  endtask

  task automatic test_slverr();
    expect_write("slverr_wr20", 8'h20, 32'hFFFFFFFF, 4'hF, 2'b10);
    expect_write("slverr_wr1c", 8'h1C, 32'hFFFFFFFF, 4'hF, 2'b10);
    expect_read("slverr_led_kept", 8'h04, 32'h5A, 2'b00);
    expect_read("slverr_rd20", 8'h20, 32'h0, 2'b10);
    expect_read("slverr_rd1c", 8'h1F, 32'h0, 2'b10);
    expect_read("addr_lsb_ignored", 8'h07, 32'h5A, 2'b00);
  endtask

  // Read and write to LED commit on the same edge: read sees the old value.
  task automatic test_same_cycle();
    bus.S_AWADDR = 8'h04; bus.S_AWVALID = 1'b1;
    bus.S_WDATA = 32'h77; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1'b1;
    bus.S_ARADDR = 8'h04; bus.S_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0; bus.S_ARVALID = 1'b0;
    checks++;
    if ({bus.S_RVALID, bus.S_RDATA, bus.S_BVALID} !== {1'b1, 32'h5A, 1'b1}) begin
      failures++;
      $display("FAIL same_cycle got rvalid=%b rdata=%h bvalid=%b want 1 5a 1",
               bus.S_RVALID, bus.S_RDATA, bus.S_BVALID);
    end
    bus.S_RREADY = 1'b1; bus.S_BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_RREADY = 1'b0; bus.S_BREADY = 1'b0;
    expect_read("same_cycle_after", 8'h04, 32'h77, 2'b00);
  endtask

  // ARVALID and RREADY held high: one read every two cycles.
  task automatic test_back_to_back();
    bus.S_ARADDR = 8'h08; bus.S_ARVALID = 1'b1; bus.S_RREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge ACLK); #1;
      checks++;
      if ({bus.S_RVALID, bus.S_ARREADY} !== ((i % 2 == 0) ? 2'b10 : 2'b01) ||
          (bus.S_RVALID === 1'b1 && bus.S_RDATA !== 32'h0000BA98)) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got rvalid=%b arready=%b rdata=%h",
                 i, bus.S_RVALID, bus.S_ARREADY, bus.S_RDATA);
      end
    end
    bus.S_ARVALID = 1'b0; bus.S_RREADY = 1'b0;
  endtask

`ifdef AXIL_PERIPH_TIMER_EN
  task automatic test_timer();
    int n;
    logic [31:0] c1, c2;
    logic [1:0]  r;
    expect_write("tmr_load", 8'h14, 32'h3, 4'hF, 2'b00);
    expect_write("tmr_irqen", 8'h10, 32'h1, 4'hF, 2'b00);
    expect_write("tmr_start", 8'h00, 32'h1, 4'hF, 2'b00);
    n = 0;
    while (IRQ_OUT !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
    checks++;
    if (IRQ_OUT !== 1'b1) begin failures++; $display("FAIL tmr_irq got=%b want 1", IRQ_OUT); end
    expect_write("tmr_stop", 8'h00, 32'h0, 4'hF, 2'b00);
    axi_read(8'h18, c1, r);
    repeat (3) @(posedge ACLK); #1;
    axi_read(8'h18, c2, r);
    checks++;
    if (c2 !== c1 || c1 > 32'd3) begin
      failures++; $display("FAIL tmr_freeze got c1=%h c2=%h want equal and <=3", c1, c2);
    end
    expect_write("tmr_w1c", 8'h0C, 32'h1, 4'h1, 2'b00);
    expect_read("tmr_status_clr", 8'h0C, 32'h0, 2'b00);
    checks++;
    if (IRQ_OUT !== 1'b0) begin failures++; $display("FAIL tmr_irq_clr got=%b want 0", IRQ_OUT); end
    expect_write("tmr_load0", 8'h14, 32'h0, 4'hF, 2'b00);
    expect_write("tmr_start0", 8'h00, 32'h1, 4'hF, 2'b00);
    expect_write("tmr_w1c_coinc", 8'h0C, 32'h1, 4'h1, 2'b00);
    expect_read("tmr_set_wins", 8'h0C, 32'h1, 2'b00);
    expect_read("tmr_count0", 8'h18, 32'h0, 2'b00);
    expect_write("tmr_off", 8'h00, 32'h0, 4'hF, 2'b00);
  endtask
`else
  task automatic test_no_timer();
    expect_write("nt_load", 8'h14, 32'h5, 4'hF, 2'b00);
    expect_write("nt_irqen", 8'h10, 32'h1, 4'hF, 2'b00);
    expect_write("nt_status", 8'h0C, 32'h1, 4'hF, 2'b00);
    expect_write("nt_count", 8'h18, 32'h9, 4'hF, 2'b00);
    expect_write("nt_ctrl", 8'h00, 32'h1, 4'hF, 2'b00);
    expect_read("nt_ctrl_bit0", 8'h00, 32'h0, 2'b00);
    for (int unsigned a = 8'h0C; a <= 8'h18; a += 4)
      expect_read("nt_reg", 8'(a), 32'h0, 2'b00);
    repeat (10) @(posedge ACLK); #1;
    checks++;
    if (IRQ_OUT !== 1'b0) begin failures++; $display("FAIL nt_irq got=%b want 0", IRQ_OUT); end
  endtask
`endif

  // Async reset with AW latched: the address must be discarded.
  task automatic test_reset_midwrite();
    bus.S_AWADDR = 8'h04; bus.S_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AWVALID = 1'b0;
    checks++;
    if (bus.S_AWREADY !== 1'b0) begin
      failures++; $display("FAIL mid_aw_latched got awready=%b want 0", bus.S_AWREADY);
    end
    #2 ARESET = 1'b1;
    #1;
    checks++;
    if ({bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, LED_OUT, SEVENSEG_OUT} !== {3'b110, 40'h0}) begin
      failures++;
      $display("FAIL mid_reset got aw/w=%b%b bvalid=%b led=%h seg=%h want 11 0 0 0",
               bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, LED_OUT, SEVENSEG_OUT);
    end
    #1 ARESET = 1'b0;
    @(posedge ACLK); #1;
    bus.S_WDATA = 32'hFF; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.S_BVALID !== 1'b0) begin
        failures++; $display("FAIL mid_no_commit cyc=%0d got bvalid=%b want 0", i, bus.S_BVALID);
      end
      @(posedge ACLK); #1;
    end
    expect_read("mid_led_cleared", 8'h04, 32'h0, 2'b00);
    expect_read("mid_seg_cleared", 8'h08, 32'h0, 2'b00);
    do_reset();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    ARESET = 1'b1;
    idle_bus();
    test_reset();
    test_aw_then_w();
    test_strobes();
    test_seg();
    test_ctrl_blank();
    test_slverr();
    test_same_cycle();
    test_back_to_back();
`ifdef AXIL_PERIPH_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    test_reset_midwrite();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
